rc4_decrypt: RTL

RC4_DECRYPT -- requirements
Module: rc4_decrypt

---
 rtl/rc4_pkg.sv | 56 +++++
 rtl/rc4_decrypt_if.sv | 60 ++++++
 rtl/rc4_char_check.sv | 21 ++
 rtl/rc4_decrypt.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rc4_pkg
//  Description : Shared definitions for the RC4 keystream decryptor: FSM
//                state encoding, S-bus mux select codes, message length
//                default and the plaintext character bounds.
//  Revision    : 1.0 - initial release
// ============================================================================
package rc4_pkg;

    // Number of message bytes processed per run unless overridden.
    localparam int MSG_LENGTH_DEFAULT = 32;

    // Clock cycles spent on one message byte, INC_I through NEXT_K.
    localparam int BYTE_CYCLES = 14;

    // Legal plaintext is lower-case a..z plus the space character.
    localparam logic [7:0] CHAR_LO_DEFAULT = 8'h61;
    localparam logic [7:0] CHAR_HI_DEFAULT = 8'h7A;
    localparam logic [7:0] CHAR_SPACE      = 8'h20;

    // S-bus mux select: which block currently owns the shared S memory.
    localparam logic [1:0] LS_INIT    = 2'd0;
    localparam logic [1:0] LS_SHUFFLE = 2'd2;
    localparam logic [1:0] LS_DECRYPT = 2'd3;

    // Decrypt FSM. WR_SETTLE separates the S[j] write from the keystream
    // read so the read never targets a word written on the preceding edge.
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_INC_I     = 4'd1,
        ST_RD_SI     = 4'd2,
        ST_WAIT_SI   = 4'd3,
        ST_STORE_SI  = 4'd4,
        ST_RD_SJ     = 4'd5,
        ST_WAIT_SJ   = 4'd6,
        ST_STORE_SJ  = 4'd7,
        ST_WR_I      = 4'd8,
        ST_WR_J      = 4'd9,
        ST_WR_SETTLE = 4'd10,
        ST_RD_F      = 4'd11,
        ST_WAIT_F    = 4'd12,
        ST_WR_OUT    = 4'd13,
        ST_NEXT_K    = 4'd14,
        ST_DONE      = 4'd15
    } rc4_state_t;

    // True when ch is space or lies inside lo..hi inclusive.
    function automatic logic char_is_legal(input logic [7:0] ch,
                                           input logic [7:0] lo,
                                           input logic [7:0] hi);
        return (ch == CHAR_SPACE) || ((ch >= lo) && (ch <= hi));
    endfunction

endpackage
`default_nettype wire

// File: rtl/rc4_decrypt_if.sv
`default_nettype none
// ============================================================================
//  Module      : rc4_decrypt_if
//  Description : Bus bundle between the RC4 decryptor and its memories:
//                S memory port, encrypted ROM port, decrypted RAM port,
//                start level, S-bus mux select and status flags.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rc4_decrypt_if;

    logic       start;
    logic [7:0] s_address;
    logic [7:0] s_data;
    logic [7:0] s_q;
    logic       s_wren;
    logic [4:0] rom_address;
    logic [7:0] rom_q;
    logic [4:0] ram_address;
    logic [7:0] ram_data;
    logic       ram_wren;
    logic [1:0] line_sel;
    logic       done;
    logic       key_invalid;

    // Decryptor side.
    modport master (
        input  start,
        input  s_q,
        input  rom_q,
        output s_address,
        output s_data,
        output s_wren,
        output rom_address,
        output ram_address,
        output ram_data,
        output ram_wren,
        output line_sel,
        output done,
        output key_invalid
    );

    // Memory / system side.
    modport slave (
        output start,
        output s_q,
        output rom_q,
        input  s_address,
        input  s_data,
        input  s_wren,
        input  rom_address,
        input  ram_address,
        input  ram_data,
        input  ram_wren,
        input  line_sel,
        input  done,
        input  key_invalid
    );

endinterface
`default_nettype wire

// File: rtl/rc4_char_check.sv
`default_nettype none
// ============================================================================
//  Module      : rc4_char_check
//  Description : Combinational plaintext filter. legal is high when data is
//                a space or falls inside CHAR_LO..CHAR_HI.
//  Revision    : 1.0 - initial release
// ============================================================================
module rc4_char_check
    import rc4_pkg::*;
#(
    parameter logic [7:0] CHAR_LO = CHAR_LO_DEFAULT,
    parameter logic [7:0] CHAR_HI = CHAR_HI_DEFAULT
) (
    input  logic [7:0] data,
    output logic       legal
);

    assign legal = char_is_legal(data, CHAR_LO, CHAR_HI);

endmodule
`default_nettype wire

// File: rtl/rc4_decrypt.sv
`default_nettype none
// ============================================================================
//  Module      : rc4_decrypt
//  Description : RC4 PRGA stage. Walks the shuffled S array, swapping S[i]
//                and S[j] for every message byte, XORs S[S[i]+S[j]] with the
//                encrypted ROM byte and writes the result to the output RAM.
//                Memory reads have one wait state (address in cycle N, data
//                sampled at the edge ending cycle N+2).
//                Optional build macro RC4_CHAR_CHECK_EN: stop at the first
//                decrypted byte outside the legal character set and flag
//                key_invalid.
//  Revision    : 1.0 - initial release
// ============================================================================
module rc4_decrypt
    import rc4_pkg::*;
#(
    parameter int         MSG_LENGTH = MSG_LENGTH_DEFAULT,
    parameter logic [7:0] CHAR_LO    = CHAR_LO_DEFAULT,
    parameter logic [7:0] CHAR_HI    = CHAR_HI_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    rc4_decrypt_if.master bus
);

    // Last message index; k itself is a 5-bit counter wrapping modulo 32.
    localparam logic [4:0] K_LAST = 5'(MSG_LENGTH - 1);

    rc4_state_t r_state;
    rc4_state_t w_next_state;

    logic [7:0] r_i;
    logic [7:0] r_j;
    logic [7:0] r_si;
    logic [7:0] r_sj;
    logic [4:0] r_k;

    logic [7:0] w_f_addr;
    logic [7:0] w_plain;
    logic       w_k_last;
    logic       w_char_legal;

    logic [7:0] w_s_address;
    logic [7:0] w_s_data;
    logic       w_s_wren;
    logic [4:0] w_rom_address;
    logic [4:0] w_ram_address;
    logic [7:0] w_ram_data;
    logic       w_ram_wren;
    logic [1:0] w_line_sel;

    // Keystream index wraps modulo 256; plaintext is keystream ^ ciphertext.
    assign w_f_addr = r_si + r_sj;
    assign w_plain  = bus.s_q ^ bus.rom_q;
    assign w_k_last = (r_k == K_LAST);

`ifdef RC4_CHAR_CHECK_EN
    logic r_key_invalid;

    rc4_char_check #(
        .CHAR_LO (CHAR_LO),
        .CHAR_HI (CHAR_HI)
    ) u_char_check (
        .data  (w_plain),
        .legal (w_char_legal)
    );

    // Latch a failed character check; cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_key_invalid <= 1'b0;
        end else if ((r_state == ST_WR_OUT) && !w_char_legal) begin
            r_key_invalid <= 1'b1;
        end
    end

    assign bus.key_invalid = r_key_invalid;
`else
    logic w_unused_char_bounds;

    assign w_char_legal         = 1'b1;
    assign w_unused_char_bounds = ^{CHAR_LO, CHAR_HI};
    assign bus.key_invalid      = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Index and captured-S registers, updated in their owning states.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_i  <= 8'h00;
            r_j  <= 8'h00;
            r_si <= 8'h00;
            r_sj <= 8'h00;
            r_k  <= 5'd0;
        end else begin
            case (r_state)
                ST_INC_I: begin
                    r_i <= r_i + 8'd1;
                end
                ST_STORE_SI: begin
                    r_si <= bus.s_q;
                    r_j  <= r_j + bus.s_q;
                end
                ST_STORE_SJ: begin
                    r_sj <= bus.s_q;
                end
                ST_NEXT_K: begin
                    if (!w_k_last) begin
                        r_k <= r_k + 5'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state and memory-port decode. Read addresses are held through
    // their wait and capture cycles; write enables last one state only.
    always_comb begin
        w_next_state  = r_state;
        w_s_address   = 8'h00;
        w_s_data      = 8'h00;
        w_s_wren      = 1'b0;
        w_rom_address = 5'd0;
        w_ram_address = 5'd0;
        w_ram_data    = 8'h00;
        w_ram_wren    = 1'b0;
        w_line_sel    = LS_DECRYPT;

        case (r_state)
            ST_IDLE: begin
                w_line_sel = LS_INIT;
                if (bus.start) begin
                    w_next_state = ST_INC_I;
                end
            end
            ST_INC_I: begin
                w_next_state = ST_RD_SI;
            end
            ST_RD_SI: begin
                w_s_address  = r_i;
                w_next_state = ST_WAIT_SI;
            end
            ST_WAIT_SI: begin
                w_s_address  = r_i;
                w_next_state = ST_STORE_SI;
            end
            ST_STORE_SI: begin
                w_s_address  = r_i;
                w_next_state = ST_RD_SJ;
            end
            ST_RD_SJ: begin
                w_s_address  = r_j;
                w_next_state = ST_WAIT_SJ;
            end
            ST_WAIT_SJ: begin
                w_s_address  = r_j;
                w_next_state = ST_STORE_SJ;
            end
            ST_STORE_SJ: begin
                w_s_address  = r_j;
                w_next_state = ST_WR_I;
            end
            ST_WR_I: begin
                w_s_address  = r_i;
                w_s_data     = r_sj;
                w_s_wren     = 1'b1;
                w_next_state = ST_WR_J;
            end
            ST_WR_J: begin
                w_s_address  = r_j;
                w_s_data     = r_si;
                w_s_wren     = 1'b1;
                w_next_state = ST_WR_SETTLE;
            end
            ST_WR_SETTLE: begin
                w_next_state = ST_RD_F;
            end
            ST_RD_F: begin
                w_s_address   = w_f_addr;
                w_rom_address = r_k;
                w_next_state  = ST_WAIT_F;
            end
            ST_WAIT_F: begin
                w_s_address   = w_f_addr;
                w_rom_address = r_k;
                w_next_state  = ST_WR_OUT;
            end
            ST_WR_OUT: begin
                w_s_address   = w_f_addr;
                w_rom_address = r_k;
                w_ram_address = r_k;
                w_ram_data    = w_plain;
                w_ram_wren    = 1'b1;
                w_next_state  = w_char_legal ? ST_NEXT_K : ST_DONE;
            end
            ST_NEXT_K: begin
                w_next_state = w_k_last ? ST_DONE : ST_INC_I;
            end
            ST_DONE: begin
                w_next_state = ST_DONE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign bus.s_address   = w_s_address;
    assign bus.s_data      = w_s_data;
    assign bus.s_wren      = w_s_wren;
    assign bus.rom_address = w_rom_address;
    assign bus.ram_address = w_ram_address;
    assign bus.ram_data    = w_ram_data;
    assign bus.ram_wren    = w_ram_wren;
    assign bus.line_sel    = w_line_sel;
    assign bus.done        = (r_state == ST_DONE);

endmodule
`default_nettype wire
